cla_adder_pipe: RTL

//   Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 4-bit

---
 rtl/cla_pkg.sv | 29 ++
 rtl/cla_group.sv | 50 +++++
 rtl/cla_adder_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Brief    : Shared types and elaboration helpers for the pipelined CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

  localparam int CLA_DEFAULT_WIDTH = 16;
  localparam int CLA_DEFAULT_GROUP = 4;

  // Control portion of a stage register; the operand/sum words are sized by
  // the instantiating module.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } cla_ctrl_t;

  function automatic int cla_ngrp(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cla_width_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// Module   : cla_group
// Brief    : Combinational GROUP-bit carry-lookahead slice.
// Revision : 1.0 - initial release
// ============================================================================
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP:0]   w_c;
  logic             w_prop;
  logic             w_term;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Each carry is a flat sum-of-products over generate/propagate terms rather
  // than a chain through the previous carry.
  always_comb begin
    w_c    = '0;
    w_prop = 1'b1;
    w_term = 1'b0;
    w_c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      w_prop = 1'b1;
      w_term = 1'b0;
      for (int j = i; j >= 0; j--) begin
        w_term = w_term | (w_g[j] & w_prop);
        w_prop = w_prop & w_p[j];
      end
      w_c[i+1] = w_term | (w_prop & cin);
    end
  end

  assign sum      = w_p ^ w_c[GROUP-1:0];
  assign cout     = w_c[GROUP];
  assign c_msb_in = w_c[GROUP-1];

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipe
// Brief    : Pipelined WIDTH-bit CLA adder/subtractor, one GROUP slice per stage.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEFAULT_WIDTH,
  parameter int GROUP = CLA_DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NGRP = cla_ngrp(WIDTH, GROUP);

  if (!cla_width_ok(WIDTH, GROUP)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  typedef struct packed {
    cla_ctrl_t        ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t           r_stage    [NGRP];
  stage_t           w_src      [NGRP];
  stage_t           w_next     [NGRP];
  logic [GROUP-1:0] w_grp_sum  [NGRP];
  logic             w_grp_cout [NGRP];
  logic             w_grp_msb  [NGRP];
  logic             w_ovf      [NGRP];
  logic             w_adv;

  // The whole pipe moves in lockstep; bubbles hold their slot.
  assign w_adv    = ~r_stage[NGRP-1].ctrl.valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction folds into the add as A + ~B with a forced carry-in.
      assign w_src[0] = '{ctrl: '{valid: in_valid, carry: in_sub | in_cin, ovf: 1'b0},
                          a:    in_a,
                          bx:   in_sub ? ~in_b : in_b,
                          sum:  {WIDTH{1'b0}}};
    end else begin : g_chain
      assign w_src[k] = r_stage[k-1];
    end

    cla_group #(
      .GROUP (GROUP)
    ) u_group (
      .a        (w_src[k].a[k*GROUP +: GROUP]),
      .b        (w_src[k].bx[k*GROUP +: GROUP]),
      .cin      (w_src[k].ctrl.carry),
      .sum      (w_grp_sum[k]),
      .cout     (w_grp_cout[k]),
      .c_msb_in (w_grp_msb[k])
    );

    if (k == NGRP - 1) begin : g_msb
      assign w_ovf[k] = w_grp_msb[k] ^ w_grp_cout[k];
    end else begin : g_inner
      assign w_ovf[k] = 1'b0;
    end

    // Sum bits of unprocessed slices are still zero, so OR-ing places the slice.
    assign w_next[k] = '{ctrl: '{valid: w_src[k].ctrl.valid, carry: w_grp_cout[k], ovf: w_ovf[k]},
                         a:    w_src[k].a,
                         bx:   w_src[k].bx,
                         sum:  w_src[k].sum | (WIDTH'(w_grp_sum[k]) << (k * GROUP))};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < NGRP; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  assign out_valid = r_stage[NGRP-1].ctrl.valid;
  assign out_sum   = r_stage[NGRP-1].sum;
  assign out_cout  = r_stage[NGRP-1].ctrl.carry;
  assign out_ovf   = r_stage[NGRP-1].ctrl.ovf;

endmodule
`default_nettype wire
